// File: rtl/epcs_pkg.sv
// Shared definitions for the EPCS flash responder: opcodes, FSM states and
// counter widths.
package epcs_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_RES       = 8'hAB;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    // The bit counter must reach 23 (24 address or dummy rises).
    localparam int BIT_CNT_W = 5;
    // Bit position inside an output byte.
    localparam int OUT_CNT_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_STATUS,
        ST_ID_DUMMY,
        ST_ID,
        ST_IGNORE
    } epcs_state_e;

endpackage

// File: rtl/epcs_pin_sync.sv
// Two-flop synchronizer for the EPCS pins (dclk, sce, sdo), plus single-clock
// rise and fall pulses for the synchronized dclk.
module epcs_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic dclk_i,
    input  logic sce_i,
    input  logic sdo_i,
    output logic dclk_rise_o,
    output logic dclk_fall_o,
    output logic sce_o,
    output logic sdo_o
);

    // Bit order is {sdo, sce, dclk}. sce resets high so the device starts deselected.
    localparam logic [2:0] PIN_RST = 3'b010;

    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic       dclk_prev_q, dclk_prev_d;

    // Next-state values: shift the pins through the two stages and keep the previous dclk.
    always_comb begin
        meta_d      = {sdo_i, sce_i, dclk_i};
        sync_d      = meta_q;
        dclk_prev_d = sync_q[0];
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q      <= PIN_RST;
            sync_q      <= PIN_RST;
            dclk_prev_q <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            sync_q      <= sync_d;
            dclk_prev_q <= dclk_prev_d;
        end
    end

    // Compare the current synchronized dclk with the previous sample to find its edges.
    always_comb begin
        dclk_rise_o = sync_q[0] & ~dclk_prev_q;
        dclk_fall_o = ~sync_q[0] & dclk_prev_q;
        sce_o       = sync_q[1];
        sdo_o       = sync_q[2];
    end

endmodule

// File: rtl/epcs_flash_responder.sv
// EPCS serial-flash responder. It decodes READ (0x03), READ STATUS (0x05) and
// READ SILICON ID (0xAB), and returns data on DATA0 from an attached sync ROM.
// When the macro EPCS_FAST_READ_EN is defined, FAST READ (0x0B) is also accepted.
// It reads ADDR, then 8 dummy bits, then DATA.
module epcs_flash_responder
    import epcs_pkg::*;
#(
    parameter int         MEM_AW     = 16,
    parameter logic [7:0] SILICON_ID = 8'h16,
    parameter logic [7:0] STATUS_VAL = 8'h00
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              epcs_dclk,
    input  logic              epcs_sce,
    input  logic              epcs_sdo,
    output logic              epcs_data0,
    output logic              epcs_data0_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata
);

    logic dclk_rise, dclk_fall, sce_s, sdo_s;

    epcs_pin_sync u_pin_sync (
        .clk         (clk_clk),
        .rst         (reset_reset),
        .dclk_i      (epcs_dclk),
        .sce_i       (epcs_sce),
        .sdo_i       (epcs_sdo),
        .dclk_rise_o (dclk_rise),
        .dclk_fall_o (dclk_fall),
        .sce_o       (sce_s),
        .sdo_o       (sdo_s)
    );

    epcs_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [MEM_AW-1:0]      addr_q, addr_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   rdv_q, rdv_d;      // mem_rdata is valid in this cycle
    logic                   fast_q, fast_d;
    logic                   data0_q, data0_d;
    logic                   oe_q, oe_d;
    logic [23:0]            sh_q, sh_d;        // incoming opcode/address shifter
    logic [7:0]             shifter_q, shifter_d;
    logic [23:0]            next_sh;

    // Control registers: the FSM, the counters and the output pins.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            out_cnt_q <= '0;
            addr_q    <= '0;
            mem_rd_q  <= 1'b0;
            rdv_q     <= 1'b0;
            fast_q    <= 1'b0;
            data0_q   <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            out_cnt_q <= out_cnt_d;
            addr_q    <= addr_d;
            mem_rd_q  <= mem_rd_d;
            rdv_q     <= rdv_d;
            fast_q    <= fast_d;
            data0_q   <= data0_d;
            oe_q      <= oe_d;
        end
    end

    // Data shifters. They carry no reset: every path that uses them loads them first.
    always_ff @(posedge clk_clk) begin
        sh_q      <= sh_d;
        shifter_q <= shifter_d;
    end

    // Next-state and output logic for the command/address/data sequencing.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        out_cnt_d = out_cnt_q;
        addr_d    = addr_q;
        mem_rd_d  = 1'b0;
        rdv_d     = mem_rd_q;
        fast_d    = fast_q;
        data0_d   = data0_q;
        oe_d      = oe_q;
        sh_d      = sh_q;
        shifter_d = shifter_q;
        next_sh   = {sh_q[22:0], sdo_s};

        // The address advances once each fetch has been presented to the ROM.
        if (mem_rd_q) begin
            addr_d = addr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
        end

        if (sce_s) begin
            // Deselect from any state. An in-flight read finishes, but DATA no longer accepts it.
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            data0_d   = 1'b0;
            bit_cnt_d = '0;
            out_cnt_d = '0;
            fast_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_CMD: begin
                    // IDLE behaves like CMD so a rise in the same cycle as select is not lost.
                    state_d = ST_CMD;
                    if (dclk_rise) begin
                        sh_d      = next_sh;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            out_cnt_d = '0;
                            case (next_sh[7:0])
                                OP_READ: state_d = ST_ADDR;
                                OP_RDSR: state_d = ST_STATUS;
                                OP_RES:  state_d = ST_ID_DUMMY;
`ifdef EPCS_FAST_READ_EN
                                OP_FAST_READ: begin
                                    state_d = ST_ADDR;
                                    fast_d  = 1'b1;
                                end
`endif
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end

                ST_ADDR: begin
                    if (dclk_rise) begin
                        sh_d      = next_sh;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            addr_d    = next_sh[MEM_AW-1:0];
                            mem_rd_d  = 1'b1;
                            state_d   = fast_q ? ST_DUMMY : ST_DATA;
                        end
                    end
                end

                ST_DUMMY: begin
                    if (rdv_q) begin
                        shifter_d = mem_rdata;
                    end
                    if (dclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            state_d   = ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (rdv_q) begin
                        shifter_d = mem_rdata;
                    end
                    if (dclk_fall) begin
                        oe_d = 1'b1;
                        // The first fall can arrive in the same cycle as the ROM data,
                        // so that byte is taken straight from mem_rdata.
                        if (rdv_q) begin
                            data0_d   = mem_rdata[7];
                            shifter_d = {mem_rdata[6:0], 1'b0};
                        end else begin
                            data0_d   = shifter_q[7];
                            shifter_d = {shifter_q[6:0], 1'b0};
                        end
                        out_cnt_d = out_cnt_q + 3'd1;
                        if (out_cnt_q == 3'd7) begin
                            mem_rd_d = 1'b1;
                        end
                    end
                end

                ST_STATUS: begin
                    if (dclk_fall) begin
                        oe_d      = 1'b1;
                        data0_d   = STATUS_VAL[3'd7 - out_cnt_q];
                        out_cnt_d = out_cnt_q + 3'd1;
                    end
                end

                ST_ID_DUMMY: begin
                    if (dclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            out_cnt_d = '0;
                            state_d   = ST_ID;
                        end
                    end
                end

                ST_ID: begin
                    if (dclk_fall) begin
                        oe_d      = 1'b1;
                        data0_d   = SILICON_ID[3'd7 - out_cnt_q];
                        out_cnt_d = out_cnt_q + 3'd1;
                    end
                end

                ST_IGNORE: begin
                    oe_d    = 1'b0;
                    data0_d = 1'b0;
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Drive the outputs from the registered state.
    always_comb begin
        epcs_data0    = data0_q;
        epcs_data0_oe = oe_q;
        mem_addr      = addr_q;
        mem_rd        = mem_rd_q;
    end

endmodule

// File: tb/tb_epcs_flash_responder.sv
// Directed bench for epcs_flash_responder.
// It plays an SPI mode-0 master and models a sync ROM with ROM[i] = i & 0xFF.
module tb_epcs_flash_responder;

    localparam int MEM_AW = 16;
    localparam int HALF   = 60;   // dclk half period in ns (clk period is 10 ns)

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dclk = 1'b0;
    logic              sce = 1'b1;
    logic              sdo = 1'b0;
    logic              data0, oe, mem_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;

    epcs_flash_responder #(.MEM_AW(MEM_AW)) dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .epcs_dclk     (dclk),
        .epcs_sce      (sce),
        .epcs_sdo      (sdo),
        .epcs_data0    (data0),
        .epcs_data0_oe (oe),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    // Sync ROM model: data is valid one clock after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem_addr[7:0];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Shift nbits out MSB first. DATA0 is sampled just before each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                        output logic oe_all, output logic oe_any);
        rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdo = tx[i];
            #(HALF);
            rx[i]  = data0;
            oe_all = oe_all & oe;
            oe_any = oe_any | oe;
            dclk = 1'b1;
            #(HALF);
            dclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        sce = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        sce = 1'b1;
        #(2 * HALF);
    endtask

    // Opcode followed by a 24-bit address.
    task automatic send_cmd_addr(input logic [7:0] op, input logic [23:0] a);
        logic [7:0] r; logic oa, on;
        xfer(op, 8, r, oa, on);
        xfer(a[23:16], 8, r, oa, on);
        xfer(a[15:8], 8, r, oa, on);
        xfer(a[7:0], 8, r, oa, on);
    endtask

    initial begin
        logic [7:0] rx;
        logic oa, on;
        int rd0;

        // Reset state
        #20;
        chk("rst_data0", data0, 0);
        chk("rst_oe", oe, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        #100;

        // READ 0x000010, three bytes
        rd0 = rd_cnt;
        cs_low();
        send_cmd_addr(8'h03, 24'h000010);
        chk("rd_oe_before_first_fall", oe, 0);
        xfer(8'h00, 8, rx, oa, on);
        chk("rd_b0", rx, 8'h10);
        chk("rd_b0_oe", oa, 1);
        xfer(8'h00, 8, rx, oa, on);
        chk("rd_b1", rx, 8'h11);
        xfer(8'h00, 8, rx, oa, on);
        chk("rd_b2", rx, 8'h12);
        cs_high();
        chk("rd_fetch_count", rd_cnt - rd0, 4);
        chk("rd_oe_after_cs", oe, 0);

        // READ at the top address, wrapping to 0
        cs_low();
        send_cmd_addr(8'h03, 24'h00FFFF);
        xfer(8'h00, 8, rx, oa, on);
        chk("wrap_b0", rx, 8'hFF);
        xfer(8'h00, 8, rx, oa, on);
        chk("wrap_b1", rx, 8'h00);
        cs_high();

        // RDSR returns STATUS_VAL repeatedly
        cs_low();
        xfer(8'h05, 8, rx, oa, on);
        for (int b = 0; b < 3; b++) begin
            xfer(8'hFF, 8, rx, oa, on);
            chk("rdsr_byte", rx, 8'h00);
            chk("rdsr_oe", oa, 1);
        end
        cs_high();

        // RES with 3 dummy bytes, then SILICON_ID repeatedly
        cs_low();
        send_cmd_addr(8'hAB, 24'h000000);
        xfer(8'h00, 8, rx, oa, on);
        chk("res_b0", rx, 8'h16);
        xfer(8'h00, 8, rx, oa, on);
        chk("res_b1", rx, 8'h16);
        cs_high();

        // Unknown opcode 0x9F is ignored until deselect
        rd0 = rd_cnt;
        cs_low();
        xfer(8'h9F, 8, rx, oa, on);
        for (int b = 0; b < 3; b++) begin
            xfer(8'hA5, 8, rx, oa, on);
            chk("unk_data0", rx, 8'h00);
            chk("unk_oe", on, 0);
        end
        cs_high();
        chk("unk_no_rd", rd_cnt - rd0, 0);
        cs_low();
        send_cmd_addr(8'h03, 24'h000010);
        xfer(8'h00, 8, rx, oa, on);
        chk("after_unk_rd", rx, 8'h10);
        cs_high();

        // Abort after 4 data bits, then a clean restart
        cs_low();
        send_cmd_addr(8'h03, 24'h000040);
        xfer(8'h00, 4, rx, oa, on);
        chk("abort_partial", rx[7:4], 4'h4);
        cs_high();
        chk("abort_oe", oe, 0);
        cs_low();
        send_cmd_addr(8'h03, 24'h000020);
        xfer(8'h00, 8, rx, oa, on);
        chk("restart_b0", rx, 8'h20);
        xfer(8'h00, 8, rx, oa, on);
        chk("restart_b1", rx, 8'h21);
        cs_high();

        // FAST READ 0x0B
        rd0 = rd_cnt;
        cs_low();
`ifdef EPCS_FAST_READ_EN
        send_cmd_addr(8'h0B, 24'h000005);
        xfer(8'h00, 8, rx, oa, on);
        chk("fast_dummy_oe", on, 0);
        chk("fast_dummy_data0", rx, 8'h00);
        xfer(8'h00, 8, rx, oa, on);
        chk("fast_b0", rx, 8'h05);
        chk("fast_b0_oe", oa, 1);
        cs_high();
        chk("fast_fetch", rd_cnt - rd0, 2);
`else
        send_cmd_addr(8'h0B, 24'h000005);
        xfer(8'h00, 8, rx, oa, on);
        chk("fast_off_data0", rx, 8'h00);
        xfer(8'h00, 8, rx, oa, on);
        chk("fast_off_oe", on, 0);
        cs_high();
        chk("fast_off_no_rd", rd_cnt - rd0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
